pwm_capture: RTL and testbench

- Input-capture peripheral: the measuring end of the PWM link; receives a PWM waveform and measures its period, high time and duty cycle.
- Exposes the results through the same acc_en_i/wr_en_i/addr_i/wdata_i/rdata_o register bus used by the PWM timer.
- Used for loopback checking of the PWM generator and for decoding external PWM sensors.

---
 rtl/pwm_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input-capture peripheral: measures period, high time and duty cycle of
// pwm_i and exposes the results on the shared acc_en/wr_en register bus.
module pwm_capture #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        acc_en_i,
  input  logic        wr_en_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  input  logic        pwm_i,
  output logic        irq_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_RISE = 2'd1;
  localparam logic [1:0] S_MEAS_HIGH = 2'd2;
  localparam logic [1:0] S_MEAS_LOW  = 2'd3;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRESC  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_HIGH   = 3'd3;
  localparam logic [2:0] A_DUTY   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  localparam int                DC_W      = $clog2(DUTY_W + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [DC_W-1:0]   DIV_STEPS = DC_W'(DUTY_W + 1);

  // control / result registers
  logic              ctrl_en, ctrl_inv, ctrl_irq_en;
  logic [15:0]       presc;
  logic [CNT_W-1:0]  period, high;
  logic [DUTY_W-1:0] duty;
  logic              valid, ovf;

  // input conditioning
  logic sync_q1, sync_q2, lvl_q;
  logic lvl, rise, fall;

  // measurement
  logic [1:0]       state;
  logic [15:0]      psc_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt_p, cnt_h, cnt_p_inc, cnt_h_inc;
  logic             run, meas, ovf_hit, done;

  // divider
  logic              busy, div_zero, q_bit;
  logic [DC_W-1:0]   div_cnt;
  logic [CNT_W:0]    div_rem;
  logic [CNT_W-1:0]  div_den, rem_sub;
  logic [DUTY_W-1:0] div_q;
  logic [DUTY_W:0]   q_next;

  // bus decode
  logic        wr, rd, clr, status_rd;
  logic [15:0] rd_mux;

  assign wr        = acc_en_i & wr_en_i;
  assign rd        = acc_en_i & ~wr_en_i;
  assign clr       = wr && (addr_i == A_CTRL) && wdata_i[2];
  assign status_rd = rd && (addr_i == A_STATUS);
  assign irq_o     = valid & ctrl_irq_en;

  // Two-stage synchroniser, polarity select, then an edge register.
  assign lvl  = sync_q2 ^ ctrl_inv;
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync_q1 <= pwm_i;
      sync_q2 <= sync_q1;
      lvl_q   <= lvl;
    end
  end

  // >= keeps the tick alive if PRESC is lowered below the running count.
  assign tick = (psc_cnt >= presc);

  always_ff @(posedge clk_i) begin
    if (rst_i)              psc_cnt <= '0;
    else if (rise || tick)  psc_cnt <= '0;
    else                    psc_cnt <= psc_cnt + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en     <= 1'b0;
      ctrl_inv    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      presc       <= '0;
    end else if (wr) begin
      if (addr_i == A_CTRL) begin
        ctrl_en     <= wdata_i[0];
        ctrl_inv    <= wdata_i[1];
        ctrl_irq_en <= wdata_i[3];
      end
      if (addr_i == A_PRESC) presc <= wdata_i;
    end
  end

  // The tick is folded into the count before the edge is acted on.
  assign cnt_p_inc = cnt_p + {{(CNT_W-1){1'b0}}, tick};
  assign cnt_h_inc = cnt_h + {{(CNT_W-1){1'b0}}, tick};
  assign run       = ctrl_en & ~clr;
  assign meas      = (state == S_MEAS_HIGH) || (state == S_MEAS_LOW);
  assign ovf_hit   = run && meas && tick && (cnt_p == CNT_MAX);
  assign done      = run && (state == S_MEAS_LOW) && rise && !ovf_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt_p <= '0;
      cnt_h <= '0;
    end else if (!ctrl_en) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_WAIT_RISE;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT_RISE;
        S_WAIT_RISE: if (rise) begin
          cnt_p <= '0;
          cnt_h <= '0;
          state <= S_MEAS_HIGH;
        end
        S_MEAS_HIGH: if (ovf_hit) begin
          state <= S_WAIT_RISE;
        end else begin
          cnt_p <= cnt_p_inc;
          cnt_h <= cnt_h_inc;
          if (fall) state <= S_MEAS_LOW;
        end
        default: if (ovf_hit) begin
          state <= S_WAIT_RISE;
        end else if (rise) begin
          cnt_p <= '0;
          cnt_h <= '0;
          state <= S_MEAS_HIGH;
        end else begin
          cnt_p <= cnt_p_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period <= '0;
      high   <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (done) begin
        period <= cnt_p_inc;
        high   <= cnt_h;
      end
      if (clr) begin
        valid <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        if (done)           valid <= 1'b1;
        else if (status_rd) valid <= 1'b0;
        if (ovf_hit)        ovf   <= 1'b1;
      end
    end
  end

  // Restoring divider; the first of DUTY_W+1 quotient bits is the 100% bit.
  assign q_bit   = (div_rem >= {1'b0, div_den});
  assign rem_sub = q_bit ? CNT_W'(div_rem - {1'b0, div_den}) : div_rem[CNT_W-1:0];
  assign q_next  = {div_q, q_bit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      div_rem  <= '0;
      div_den  <= '0;
      div_q    <= '0;
      div_zero <= 1'b0;
      duty     <= '0;
    end else if (!ctrl_en) begin
      busy <= 1'b0;
    end else if (done) begin
      busy     <= 1'b1;
      div_cnt  <= DIV_STEPS;
      div_rem  <= {1'b0, cnt_h};
      div_den  <= cnt_p_inc;
      div_zero <= (cnt_p_inc == '0);
      div_q    <= '0;
    end else if (busy) begin
      div_q   <= q_next[DUTY_W-1:0];
      div_rem <= {rem_sub, 1'b0};
      div_cnt <= div_cnt - 1'b1;
      if (div_cnt == DC_W'(1)) begin
        busy <= 1'b0;
        duty <= div_zero ? '0 : (q_next[DUTY_W] ? DUTY_MAX : q_next[DUTY_W-1:0]);
      end
    end
  end

  always_comb begin
    // NOTE: assign a default first so no path leaves rd_mux unassigned (no latch).
    rd_mux = '0;
    case (addr_i)
      A_CTRL:   rd_mux = {12'd0, ctrl_irq_en, 1'b0, ctrl_inv, ctrl_en};
      A_PRESC:  rd_mux = presc;
      A_PERIOD: rd_mux = 16'(period);
      A_HIGH:   rd_mux = 16'(high);
      A_DUTY:   rd_mux = 16'(duty);
      A_STATUS: rd_mux = {12'd0, sync_q2, busy, ovf, valid};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)   rdata_o <= '0;
    else if (rd) rdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table vectors, directed corner cases and
// randomized waveforms checked against an arithmetic reference model.
module tb_pwm_capture;

  localparam int DUTY_W = 10;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRESC  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_HIGH   = 3'd3;
  localparam logic [2:0] A_DUTY   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic        clk_i    = 1'b0;
  logic        rst_i    = 1'b1;
  logic        acc_en_i = 1'b0;
  logic        wr_en_i  = 1'b0;
  logic [2:0]  addr_i   = '0;
  logic [15:0] wdata_i  = '0;
  logic [15:0] rdata_o;
  logic        pwm_i    = 1'b0;
  logic        irq_o;

  int n_vec  = 0;
  int n_miss = 0;

  // waveform generator controls: mode 0 drives gen_level, mode 1 runs gen_hi/gen_lo
  int   gen_mode  = 0;
  logic gen_level = 1'b0;
  int   gen_hi    = 10;
  int   gen_lo    = 30;
  int   gen_left  = 0;

  typedef struct {
    int hi;
    int lo;
    int presc;
    bit inv;
    int period;
    int high;
    int duty;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] rv;
  int          r_hi, r_lo, r_p, r_per, r_high;
  bit          r_inv;

  pwm_capture #(.CNT_W(16), .DUTY_W(DUTY_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .acc_en_i (acc_en_i),
    .wr_en_i  (wr_en_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .pwm_i    (pwm_i),
    .irq_o    (irq_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin : pwm_gen
    forever begin
      @(posedge clk_i); #1;
      if (gen_mode == 0) begin
        pwm_i    = gen_level;
        gen_left = 0;
      end else if (gen_left <= 1) begin
        pwm_i    = ~pwm_i;
        gen_left = pwm_i ? gen_hi : gen_lo;
      end else begin
        gen_left--;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    acc_en_i = 1'b1; wr_en_i = 1'b1; addr_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    acc_en_i = 1'b0; wr_en_i = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    acc_en_i = 1'b1; wr_en_i = 1'b0; addr_i = a;
    @(posedge clk_i); #1;
    acc_en_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n = 0;
    while (irq_o !== 1'b1 && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    check(name, {15'd0, irq_o}, 16'd1);
  endtask

  // Reference: floor(high * 2^DUTY_W / period), saturated, 0 for a zero period.
  function automatic int model_duty(input int per, input int hi);
    int d;
    if (per == 0) return 0;
    d = (hi * (1 << DUTY_W)) / per;
    return (d > (1 << DUTY_W) - 1) ? (1 << DUTY_W) - 1 : d;
  endfunction

  task automatic apply_cfg(input int hi, input int lo, input int p, input bit inv);
    gen_hi = hi; gen_lo = lo; gen_mode = 1;
    bus_write(A_PRESC, 16'(p));
    bus_write(A_CTRL, {12'd0, 1'b0, 1'b1, inv, 1'b1});
  endtask

  task automatic check_results(input string tag, input int per, input int hi, input int dt);
    logic [15:0] d;
    bus_read(A_PERIOD, d); check({tag, "_period"}, d, 16'(per));
    bus_read(A_HIGH, d);   check({tag, "_high"}, d, 16'(hi));
    bus_read(A_DUTY, d);   check({tag, "_duty"}, d, 16'(dt));
    bus_read(A_STATUS, d); check({tag, "_ovf"}, d & 16'h0002, 16'h0000);
  endtask

  initial begin
    tbl[0] = '{10, 30, 0, 1'b0, 40, 10, 256};
    tbl[1] = '{200, 200, 3, 1'b0, 100, 50, 512};
    tbl[2] = '{300, 100, 3, 1'b0, 100, 75, 768};
    tbl[3] = '{10, 30, 0, 1'b1, 40, 30, 768};
    tbl[4] = '{7, 13, 1, 1'b0, 10, 3, 307};
    tbl[5] = '{25, 5, 4, 1'b0, 6, 5, 853};

    // reset: all registers read back zero
    idle(2);
    rst_i = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rv);
      check($sformatf("reset_addr%0d", a), rv, 16'h0000);
    end
    check("reset_irq", {15'd0, irq_o}, 16'd0);

    // 10/30 at PRESC=0: result timing, divider latency and STATUS read-clear
    gen_hi = 10; gen_lo = 30; gen_mode = 1;
    bus_write(A_PRESC, 16'd0);
    bus_write(A_CTRL, 16'h0009);
    wait_irq(300, "first_result_irq");
    bus_read(A_DUTY, rv);   check("duty_before_div", rv, 16'd0);
    bus_read(A_PERIOD, rv); check("period_10_30", rv, 16'd40);
    bus_read(A_HIGH, rv);   check("high_10_30", rv, 16'd10);
    idle(7);
    bus_read(A_DUTY, rv);   check("duty_edge10", rv, 16'd0);
    bus_read(A_DUTY, rv);   check("duty_edge11", rv, 16'd256);
    bus_read(A_STATUS, rv); check("status_valid", rv & 16'hFFF7, 16'h0001);
    bus_read(A_STATUS, rv); check("status_cleared", rv & 16'h0001, 16'h0000);
    check("irq_after_clear", {15'd0, irq_o}, 16'd0);

    // STATUS read on the very edge that sets VALID: the set wins
    bus_read(A_STATUS, rv);
    wait_irq(100, "race_irq");
    bus_read(A_STATUS, rv); check("race_valid_pre", rv & 16'h0001, 16'h0001);
    idle(38);
    bus_read(A_STATUS, rv); check("race_read_data", rv & 16'h0001, 16'h0000);
    check("race_set_wins", {15'd0, irq_o}, 16'd1);
    bus_read(A_STATUS, rv); check("race_valid_post", rv & 16'h0001, 16'h0001);

    // IRQ_EN gates irq_o
    bus_write(A_CTRL, 16'h0001);
    idle(50);
    check("irq_masked", {15'd0, irq_o}, 16'd0);
    bus_write(A_CTRL, 16'h0009);
    check("irq_unmasked", {15'd0, irq_o}, 16'd1);

    // EN dropped mid MEAS_LOW: no register update
    bus_read(A_STATUS, rv);
    wait_irq(100, "abort_irq");
    bus_read(A_STATUS, rv);
    gen_lo = 50;
    idle(17);
    bus_write(A_CTRL, 16'h0000);
    idle(80);
    bus_read(A_STATUS, rv); check("abort_valid", rv & 16'h0003, 16'h0000);
    bus_read(A_PERIOD, rv); check("abort_period", rv, 16'd40);
    check("abort_irq_low", {15'd0, irq_o}, 16'd0);

    // overflow: input stuck high after one rising edge
    gen_level = 1'b0; gen_mode = 0;
    bus_write(A_PRESC, 16'd0);
    bus_write(A_CTRL, 16'h0005);
    idle(5);
    gen_level = 1'b1;
    idle(65525);
    bus_read(A_STATUS, rv); check("ovf_not_yet", rv & 16'h0003, 16'h0000);
    idle(20);
    bus_read(A_STATUS, rv); check("ovf_set", rv & 16'h0003, 16'h0002);
    bus_read(A_PERIOD, rv); check("ovf_period_kept", rv, 16'd40);
    bus_write(A_CTRL, 16'h0005);
    bus_read(A_STATUS, rv); check("ovf_cleared", rv & 16'h0003, 16'h0000);

    // table-driven steady-state vectors
    for (int i = 0; i < 6; i++) begin
      apply_cfg(tbl[i].hi, tbl[i].lo, tbl[i].presc, tbl[i].inv);
      idle(4 * (tbl[i].hi + tbl[i].lo) + 350);
      check_results($sformatf("tbl%0d", i), tbl[i].period, tbl[i].high, tbl[i].duty);
    end

    // edges 5 clk apart: divider restarts each result, only the last completes
    gen_level = 1'b0; gen_mode = 0;
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PRESC, 16'd0);
    gen_hi = 5; gen_lo = 5; gen_mode = 1;
    bus_write(A_CTRL, 16'h0005);
    idle(60);
    bus_read(A_DUTY, rv);   check("fast_duty_held", rv, 16'd853);
    bus_read(A_PERIOD, rv); check("fast_period", rv, 16'd10);
    gen_level = pwm_i; gen_mode = 0;
    idle(30);
    bus_read(A_DUTY, rv);   check("fast_duty_final", rv, 16'(model_duty(10, 5)));
    bus_read(A_STATUS, rv); check("fast_not_busy", rv & 16'h0004, 16'h0000);

    // randomized waveforms against the reference model
    for (int i = 0; i < 12; i++) begin
      r_hi   = $urandom_range(6, 60);
      r_lo   = $urandom_range(6, 60);
      r_p    = $urandom_range(0, 3);
      r_inv  = 1'($urandom_range(0, 1));
      r_per  = (r_hi + r_lo) / (r_p + 1);
      r_high = (r_inv ? r_lo : r_hi) / (r_p + 1);
      apply_cfg(r_hi, r_lo, r_p, r_inv);
      idle(4 * (r_hi + r_lo) + 150);
      check_results($sformatf("rnd%0d_h%0d_l%0d_p%0d_i%0d", i, r_hi, r_lo, r_p, r_inv),
                    r_per, r_high, model_duty(r_per, r_high));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
